// File: rtl/sparc_mem_pkg.sv
// rtl/sparc_mem_pkg.sv - shared RAM opcodes and dump-reader FSM encoding
package sparc_mem_pkg;

  localparam logic [5:0] OP_LOAD_WORD = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RELEASE = 3'd2,
    ST_OUT     = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/mfc_timeout_counter.sv
// rtl/mfc_timeout_counter.sv - per-phase cycle counter flagging a missing MFC edge
module mfc_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // expired marks the last allowed cycle of the phase; the count saturates there
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - reads a run of RAM words over a 4-phase MFC handshake and streams them out
module mem_dump_reader
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        word_count,
  output logic              RAM_enable,
  output logic [5:0]        RAM_OpCode,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_data_in,
  input  logic              MFC,
  output logic [31:0]       dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, next_addr, aligned_addr;
  logic [7:0]        remaining_q, remaining_d;
  logic              ram_enable_q, ram_enable_d;
  logic [5:0]        ram_opcode_q, ram_opcode_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       dump_data_q, dump_data_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic              dump_valid_q, dump_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              tmo_expired;

  assign aligned_addr = {start_addr[ADDR_W-1:2], 2'b00};

  // Any state change restarts the count, so each phase gets its own budget
  mfc_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .Clk    (Clk),
    .RESET  (RESET),
    .clear  (state_d != state_q),
    .enable ((state_q == ST_REQ) || (state_q == ST_RELEASE)),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    ram_enable_d = ram_enable_q;
    ram_opcode_d = ram_opcode_q;
    ram_addr_d   = ram_addr_q;
    dump_data_d  = dump_data_q;
    dump_addr_d  = dump_addr_q;
    dump_valid_d = dump_valid_q;
    error_d      = error_q;
    next_addr    = addr_q + ADDR_W'(4);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = aligned_addr;
          remaining_d = word_count;
          error_d     = 1'b0;
          if (word_count == 8'd0) begin
            state_d = ST_FINISH;
          end else begin
            state_d      = ST_REQ;
            ram_enable_d = 1'b1;
            ram_opcode_d = OP_LOAD_WORD;
            ram_addr_d   = aligned_addr;
          end
        end
      end
      ST_REQ: begin
        if (MFC) begin
          dump_data_d  = ram_data_in;
          dump_addr_d  = addr_q;
          ram_enable_d = 1'b0;
          state_d      = ST_RELEASE;
        end else if (tmo_expired) begin
          error_d      = 1'b1;
          ram_enable_d = 1'b0;
          state_d      = ST_FINISH;
        end
      end
      ST_RELEASE: begin
        if (!MFC) begin
          dump_valid_d = 1'b1;
          state_d      = ST_OUT;
        end else if (tmo_expired) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_OUT: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          remaining_d  = remaining_q - 8'd1;
          addr_d       = next_addr;
          if (remaining_q > 8'd1) begin
            state_d      = ST_REQ;
            ram_enable_d = 1'b1;
            ram_opcode_d = OP_LOAD_WORD;
            ram_addr_d   = next_addr;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      ram_enable_q <= 1'b0;
      ram_opcode_q <= '0;
      ram_addr_q   <= '0;
      dump_data_q  <= '0;
      dump_addr_q  <= '0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      ram_enable_q <= ram_enable_d;
      ram_opcode_q <= ram_opcode_d;
      ram_addr_q   <= ram_addr_d;
      dump_data_q  <= dump_data_d;
      dump_addr_q  <= dump_addr_d;
      dump_valid_q <= dump_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign RAM_enable = ram_enable_q;
  assign RAM_OpCode = ram_opcode_q;
  assign ram_addr   = ram_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_addr  = dump_addr_q;
  assign dump_valid = dump_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - self-checking bench for mem_dump_reader against a RAM/consumer model
module tb_mem_dump_reader;

  localparam int AW = 9;
  localparam int TO = 20;
  localparam int MEMSZ = 1 << AW;

  logic          Clk = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [7:0]    word_count = '0;
  logic          RAM_enable;
  logic [5:0]    RAM_OpCode;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data_in = '0;
  logic          MFC = 1'b0;
  logic [31:0]   dump_data;
  logic [AW-1:0] dump_addr;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic          busy, done, error;

  mem_dump_reader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .RESET(RESET), .start(start), .start_addr(start_addr),
    .word_count(word_count), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .MFC(MFC),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          sa;
    int          wc;
    int          pct;
    logic [31:0] exp_first_data;
    int          exp_first_addr;
    int          exp_last_addr;
  } vec_t;

  byte unsigned  mem [0:MEMSZ-1];
  int            vectors = 0;
  int            miscompares = 0;
  int            ready_pct = 100;
  bit            mfc_dead = 1'b0;
  bit            hold_mfc = 1'b0;
  int            done_cnt = 0;
  int            en_cnt = 0;
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];

  function automatic logic [31:0] word_at(input int a);
    return {mem[a % MEMSZ], mem[(a + 1) % MEMSZ], mem[(a + 2) % MEMSZ], mem[(a + 3) % MEMSZ]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // RAM model: answers a request after a random delay, releases MFC after a random delay
  initial begin
    forever begin
      @(negedge Clk);
      if (RESET) begin
        MFC = 1'b0;
      end else if (RAM_enable && !MFC && !mfc_dead) begin
        if ($urandom_range(0, 2) == 0) begin
          ram_data_in = word_at(int'(ram_addr));
          MFC = 1'b1;
        end
      end else if (!RAM_enable && MFC && !hold_mfc) begin
        if ($urandom_range(0, 2) == 0) MFC = 1'b0;
      end
    end
  end

  // Consumer and activity monitor
  initial begin
    forever begin
      @(negedge Clk);
      dump_ready = ($urandom_range(1, 100) <= ready_pct);
      if (dump_valid && dump_ready) begin
        got_addr.push_back(dump_addr);
        got_data.push_back(dump_data);
      end
      if (done) done_cnt++;
      if (RAM_enable) en_cnt++;
    end
  end

  task automatic launch(input int sa, input int wc);
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    en_cnt = 0;
    start_addr = AW'(sa);
    word_count = 8'(wc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_dump(input int sa, input int n, input bit exp_err, input string tag);
    int cyc = 0;
    int base = sa & ~3;
    while (done_cnt == 0 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({tag, " done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
    check({tag, " done_once"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_idle"}, 64'(busy), 64'd0);
    check({tag, " error"}, 64'(error), 64'(exp_err));
    check({tag, " word_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({tag, " addr"}, 64'(got_addr[i]), 64'((base + 4 * i) % MEMSZ));
      check({tag, " data"}, 64'(got_data[i]), 64'(word_at((base + 4 * i) % MEMSZ)));
    end
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    logic [31:0] held_data;
    logic [AW-1:0] held_addr;

    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    {mem[224], mem[225], mem[226], mem[227]} = 32'h01020304;
    {mem[228], mem[229], mem[230], mem[231]} = 32'hAABBCCDD;
    {mem[232], mem[233], mem[234], mem[235]} = 32'hFFFFFFFF;
    {mem[508], mem[509], mem[510], mem[511]} = 32'hDEADBEEF;
    {mem[0], mem[1], mem[2], mem[3]} = 32'h11223344;

    vecs.push_back('{224, 3, 100, 32'h01020304, 224, 232});
    vecs.push_back('{226, 1, 100, 32'h01020304, 224, 224});
    vecs.push_back('{508, 2,  70, 32'hDEADBEEF, 508, 0});
    vecs.push_back('{  1, 4,  50, 32'h11223344, 0, 12});

    repeat (2) tick();
    check("reset RAM_enable", 64'(RAM_enable), 64'd0);
    check("reset outputs", 64'({RAM_OpCode, ram_addr, dump_addr, dump_valid, busy, done, error}), 64'd0);
    check("reset dump_data", 64'(dump_data), 64'd0);
    RESET = 1'b0;
    tick();

    foreach (vecs[k]) begin
      ready_pct = vecs[k].pct;
      launch(vecs[k].sa, vecs[k].wc);
      finish_dump(vecs[k].sa, vecs[k].wc, 1'b0, $sformatf("vec%0d", k));
      if (got_data.size() > 0) begin
        check($sformatf("vec%0d first_data", k), 64'(got_data[0]), 64'(vecs[k].exp_first_data));
        check($sformatf("vec%0d first_addr", k), 64'(got_addr[0]), 64'(vecs[k].exp_first_addr));
        check($sformatf("vec%0d last_addr", k), 64'(got_addr[got_addr.size() - 1]), 64'(vecs[k].exp_last_addr));
      end
    end

    for (int r = 0; r < 8; r++) begin
      int sa = $urandom_range(0, MEMSZ - 1);
      int wc = $urandom_range(1, 6);
      ready_pct = $urandom_range(30, 100);
      launch(sa, wc);
      finish_dump(sa, wc, 1'b0, $sformatf("rand%0d", r));
    end

    // Launch latency, stable request, and start ignored while busy
    ready_pct = 50;
    start_addr = AW'(301);
    word_count = 8'd4;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    start = 1'b1;
    tick();
    check("latency RAM_enable", 64'(RAM_enable), 64'd1);
    check("latency busy", 64'(busy), 64'd1);
    check("latency opcode/addr", 64'({RAM_OpCode, ram_addr}), 64'({6'b000000, 9'd300}));
    start = 1'b0;
    repeat (3) tick();
    start_addr = '0;
    word_count = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_dump(300, 4, 1'b0, "busy_start");

    // Consumer stalls: output must hold and no new request may issue
    ready_pct = 0;
    launch(228, 2);
    cyc = 0;
    while (!dump_valid && cyc < 500) begin
      tick();
      cyc++;
    end
    check("stall valid_reached", 64'(dump_valid), 64'd1);
    held_data = dump_data;
    held_addr = dump_addr;
    en_cnt = 0;
    repeat (10) tick();
    check("stall valid_held", 64'(dump_valid), 64'd1);
    check("stall data_held", 64'(dump_data), 64'(held_data));
    check("stall addr_held", 64'(dump_addr), 64'(held_addr));
    check("stall no_request", 64'(en_cnt), 64'd0);
    ready_pct = 100;
    finish_dump(228, 2, 1'b0, "stall");

    // MFC never arrives
    mfc_dead = 1'b1;
    launch(224, 2);
    finish_dump(224, 0, 1'b1, "timeout");
    check("timeout RAM_enable", 64'(RAM_enable), 64'd0);
    check("timeout req_cycles", 64'(en_cnt), 64'(TO));
    repeat (4) tick();
    check("timeout error_sticky", 64'(error), 64'd1);
    mfc_dead = 1'b0;

    // Empty dump, also clears the sticky error
    launch(100, 0);
    finish_dump(100, 0, 1'b0, "empty");
    check("empty no_request", 64'(en_cnt), 64'd0);

    // Reset while waiting for MFC release
    hold_mfc = 1'b1;
    ready_pct = 100;
    launch(224, 3);
    cyc = 0;
    while (!(MFC && !RAM_enable && busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("midreset reached_release", 64'(MFC && !RAM_enable && busy), 64'd1);
    RESET = 1'b1;
    #1;
    check("midreset ctrl", 64'({RAM_enable, RAM_OpCode, ram_addr, busy, done, error, dump_valid}), 64'd0);
    check("midreset dump", 64'({dump_data, dump_addr}), 64'd0);
    hold_mfc = 1'b0;
    repeat (2) tick();
    RESET = 1'b0;
    repeat (3) tick();
    check("midreset no_done", 64'(done_cnt), 64'd0);
    launch(224, 3);
    finish_dump(224, 3, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
- REQ-001 SHALL have parameter ADDR_W, default 9, giving the byte-address width of the RAM port.
- REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum number of cycles to wait for MFC per phase.
- REQ-003 SHALL have input Clk, 1 bit: the single clock; all state changes occur on its rising edge.
- REQ-004 SHALL have input RESET, 1 bit: asynchronous, active-high reset.
- REQ-005 SHALL have input start, 1 bit: one-cycle pulse that launches a dump.
- REQ-006 SHALL have input start_addr, ADDR_W bits: first byte address of the dump.
- REQ-007 SHALL have input word_count, 8 bits: number of 32-bit words to read.
- REQ-008 SHALL have output RAM_enable, 1 bit: request strobe to RAM.
- REQ-009 SHALL have output RAM_OpCode, 6 bits: RAM operation code.
- REQ-010 SHALL have output ram_addr, ADDR_W bits: byte address presented to RAM.
- REQ-011 SHALL have input ram_data_in, 32 bits: RAM read data, big-endian (Mem[a] in bits 31:24).
- REQ-012 SHALL have input MFC, 1 bit: memory-function-complete from RAM.
- REQ-013 SHALL have outputs dump_data (32 bits), dump_addr (ADDR_W bits) and dump_valid (1 bit): the output word stream.
- REQ-014 SHALL have input dump_ready, 1 bit: consumer accepts the output word.
- REQ-015 SHALL have outputs busy, done and error, 1 bit each.

Function
- REQ-016 SHALL use FSM states IDLE, REQ, RELEASE, OUT, FINISH.
- REQ-017 IDLE: on start, SHALL latch {start_addr[ADDR_W-1:2],2'b00} and word_count, then go to REQ next edge, or to FINISH if word_count is 0.
- REQ-018 REQ: SHALL drive RAM_enable=1, RAM_OpCode=6'b000000 (load word) and ram_addr=current address, holding all three stable until MFC=1 is sampled.
- REQ-019 On the edge sampling MFC=1 in REQ, SHALL capture ram_data_in into dump_data and current address into dump_addr, drop RAM_enable, and go to RELEASE.
- REQ-020 RELEASE: SHALL wait until MFC=0 (4-phase handshake), then go to OUT.
- REQ-021 OUT: SHALL assert dump_valid; dump_data and dump_addr SHALL stay stable until dump_valid&&dump_ready is sampled.
- REQ-022 On handshake in OUT, SHALL decrement the remaining count and advance the address by 4 modulo 2^ADDR_W (wrap to 0); then go to REQ if remaining >0, else to FINISH.
- REQ-023 FINISH: SHALL pulse done for exactly one cycle, then return to IDLE.
- REQ-024 busy SHALL be 1 in every state except IDLE.
- REQ-025 start while busy SHALL be ignored.
- REQ-026 Latency: start sampled at edge N SHALL give RAM_enable=1 from edge N+1.
- REQ-027 A cycle counter SHALL reset on each state entry; if MFC is not seen in REQ (or not released in RELEASE) within TIMEOUT cycles, the FSM SHALL set error=1 sticky, drop RAM_enable and go to FINISH.
- REQ-028 error SHALL clear only on RESET or on the next accepted start.

Reset
- REQ-029 RESET SHALL asynchronously force IDLE, RAM_enable=0, RAM_OpCode=0, ram_addr=0, dump_data=0, dump_addr=0, dump_valid=0, busy=0, done=0, error=0, counters=0.
- REQ-030 RESET mid-transfer SHALL abandon the dump with no done pulse; after RESET deasserts, the FSM SHALL accept a new start.

Structure
- REQ-031 The RAM opcode constants (load word 6'b000000) and the FSM state encoding SHALL live in the shared package sparc_mem_pkg.
- REQ-032 The timeout counter SHALL be one sub-module, mfc_timeout_counter (inputs clear and enable, output expired).

Verification
- REQ-033 Memory 224..235 = 0x01020304, 0xAABBCCDD, 0xFFFFFFFF; start_addr=224, word_count=3, dump_ready=1 -> words 0x01020304, 0xAABBCCDD, 0xFFFFFFFF at dump_addr 224, 228, 232; done pulses once; error=0.
- REQ-034 start_addr=226, word_count=1 -> dump_addr=224 and the word at 224.
- REQ-035 start_addr=508, word_count=2, ADDR_W=9 -> dump_addr 508 then 0.
- REQ-036 dump_ready held 0 for 10 cycles -> dump_valid and dump_data stable and no new RAM_enable; release ready -> dump continues.
- REQ-037 MFC tied 0 -> error=1 after TIMEOUT cycles, done pulses, RAM_enable=0; word_count=0 -> done with no RAM_enable.
- REQ-038 RESET asserted in RELEASE -> all outputs zero immediately; next start is accepted and runs normally.
